// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the single SDRAM controller burst port between the cache line-fill
// reader (port R) and the write-combining buffer flusher (port W). A whole
// 4-word burst is granted at a time; the controller's per-word strobes and data
// are routed to the granted requester. Reads win by default, but after
// WR_STARVE_MAX consecutive read grants taken while a write was waiting, the
// write is forced through.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rd_req/rd_addr    fill request (level) and line address
//   rd_fill/rd_data   per-word strobe and data returned to the cache
//   wr_req/wr_addr    flush request (level, held until wr_done) and address
//   wr_dqm            byte masks for the 4 words (1 = masked)
//   wr_wordreq        buffer must present word wr_wordidx on wr_data now
//   wr_wordidx        index of the word being written
//   wr_data           write word from the buffer
//   wr_done           one-cycle pulse after the 4th word is written
//   sdram_req/rw/addr/dqm  burst request towards the controller
//   data_to_sdram     write word towards the controller
//   sdram_fill        read word valid from the controller
//   data_from_sdram   read word from the controller
//   sdram_wrstrobe    controller consumes a write word this cycle
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int WR_STARVE_MAX = 4,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_fill,
  output logic [15:0]       rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_dqm,
  output logic              wr_wordreq,
  output logic [1:0]        wr_wordidx,
  input  logic [15:0]       wr_data,
  output logic              wr_done,
  output logic              sdram_req,
  output logic              sdram_rw,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_dqm,
  output logic [15:0]       data_to_sdram,
  input  logic              sdram_fill,
  input  logic [15:0]       data_from_sdram,
  input  logic              sdram_wrstrobe
);

  localparam int STARVE_W = (WR_STARVE_MAX < 1) ? 1 : $clog2(WR_STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(WR_STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE_C = STARVE_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    TURN     = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [1:0]          word_cnt_r;
  logic [STARVE_W-1:0] starve_cnt_r;

  logic                sdram_req_r;
  logic                sdram_rw_r;
  logic [ADDR_W-1:0]   sdram_addr_r;
  logic [7:0]          sdram_dqm_r;
  logic                wr_done_r;

  logic                grant_rd_s;
  logic                grant_wr_s;
  logic                rd_strobe_s;
  logic                wr_strobe_s;
  logic                burst_strobe_s;
  logic                last_word_s;

  // Low address bits select a word inside the burst and are dropped.
  logic                addr_lsb_unused_s;
  assign addr_lsb_unused_s = ^{rd_addr[2:0], wr_addr[2:0]};

  // Only the strobe matching the current burst direction is honoured;
  // strobes in any other state are ignored entirely.
  assign rd_strobe_s    = (state_r == RD_BURST) && sdram_fill;
  assign wr_strobe_s    = (state_r == WR_BURST) && sdram_wrstrobe;
  assign burst_strobe_s = rd_strobe_s || wr_strobe_s;
  assign last_word_s    = burst_strobe_s && (word_cnt_r == 2'd3);

  // Grant decision: reads win unless the write has waited out its allowance.
  always_comb begin
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (state_r == IDLE) begin
      if (wr_req && (!rd_req || (starve_cnt_r == STARVE_MAX_C))) begin
        grant_wr_s = 1'b1;
      end else if (rd_req) begin
        grant_rd_s = 1'b1;
      end else begin
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
      end
    end else begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_rd_s) begin
          state_s = RD_BURST;
        end else if (grant_wr_s) begin
          state_s = WR_BURST;
        end else begin
          state_s = IDLE;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_word_s) begin
          state_s = TURN;
        end else begin
          state_s = state_r;
        end
      end
      TURN:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Burst bookkeeping: request/address/mask registers, word and starvation counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sdram_req_r  <= 1'b0;
      sdram_rw_r   <= 1'b1;
      sdram_addr_r <= '0;
      sdram_dqm_r  <= 8'hFF;
      wr_done_r    <= 1'b0;
      word_cnt_r   <= 2'd0;
      starve_cnt_r <= '0;
    end else begin
      wr_done_r <= wr_strobe_s && last_word_s;
      case (state_r)
        IDLE: begin
          if (grant_rd_s) begin
            sdram_addr_r <= {rd_addr[ADDR_W-1:3], 3'b000};
            sdram_rw_r   <= 1'b1;
            sdram_req_r  <= 1'b1;
            sdram_dqm_r  <= 8'h00;
            // A read taken while a write waits counts towards the write's allowance.
            if (wr_req) begin
              starve_cnt_r <= (starve_cnt_r == STARVE_MAX_C) ? starve_cnt_r
                                                             : starve_cnt_r + STARVE_ONE_C;
            end else begin
              starve_cnt_r <= '0;
            end
          end else if (grant_wr_s) begin
            sdram_addr_r <= {wr_addr[ADDR_W-1:3], 3'b000};
            sdram_rw_r   <= 1'b0;
            sdram_req_r  <= 1'b1;
            sdram_dqm_r  <= wr_dqm;
            starve_cnt_r <= '0;
          end else begin
            sdram_req_r <= 1'b0;
          end
        end
        RD_BURST, WR_BURST: begin
          // The first honoured strobe shows the controller has accepted the burst.
          if (burst_strobe_s) begin
            sdram_req_r <= 1'b0;
            word_cnt_r  <= word_cnt_r + 2'd1;
          end else begin
            word_cnt_r  <= word_cnt_r;
          end
        end
        TURN: begin
          word_cnt_r  <= 2'd0;
          sdram_dqm_r <= 8'hFF;
        end
        default: begin
          word_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  // Output steering: strobes and data pass through combinationally to the granted side.
  always_comb begin
    rd_fill       = 1'b0;
    rd_data       = 16'h0000;
    wr_wordreq    = 1'b0;
    data_to_sdram = 16'h0000;
    wr_wordidx    = word_cnt_r;
    case (state_r)
      RD_BURST: begin
        rd_fill = rd_strobe_s;
        rd_data = data_from_sdram;
      end
      WR_BURST: begin
        wr_wordreq    = wr_strobe_s;
        data_to_sdram = wr_data;
      end
      default: begin
        rd_fill    = 1'b0;
        wr_wordreq = 1'b0;
      end
    endcase
  end

  assign sdram_req  = sdram_req_r;
  assign sdram_rw   = sdram_rw_r;
  assign sdram_addr = sdram_addr_r;
  assign sdram_dqm  = sdram_dqm_r;
  assign wr_done    = wr_done_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Self-checking bench for sdram_port_arbiter. The bench plays the SDRAM
// controller and both requesters. Pending requests are kept in queues and the
// expected grant is derived from the arbitration rule (reads first, a write
// forced through after 4 read grants taken while it waited).
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int STARVE = 4;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  dqm;
  } wreq_t;

  typedef struct {
    bit          rd;
    bit          fill;
    logic [15:0] din;
    bit          e_req;
    bit          e_rw;
    bit          e_fill;
    logic [15:0] e_data;
    logic [31:0] e_addr;
    logic [7:0]  e_dqm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_fill;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_dqm;
  logic        wr_wordreq;
  logic [1:0]  wr_wordidx;
  logic [15:0] wr_data;
  logic        wr_done;
  logic        sdram_req;
  logic        sdram_rw;
  logic [31:0] sdram_addr;
  logic [7:0]  sdram_dqm;
  logic [15:0] data_to_sdram;
  logic        sdram_fill;
  logic [15:0] data_from_sdram;
  logic        sdram_wrstrobe;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cyc  = 0;
  int last_c4  = 0;
  int streak   = 0;
  bit inject   = 1'b0;
  bit add_wr_mid = 1'b0;

  logic [31:0] rd_q[$];
  wreq_t       wr_q[$];
  vec_t        vt[8];

  sdram_port_arbiter #(.WR_STARVE_MAX(STARVE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_fill(rd_fill), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_dqm(wr_dqm),
    .wr_wordreq(wr_wordreq), .wr_wordidx(wr_wordidx), .wr_data(wr_data), .wr_done(wr_done),
    .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm),
    .data_to_sdram(data_to_sdram), .sdram_fill(sdram_fill),
    .data_from_sdram(data_from_sdram), .sdram_wrstrobe(sdram_wrstrobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    rd_req  = (rd_q.size() > 0);
    rd_addr = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
    wr_req  = (wr_q.size() > 0);
    wr_addr = (wr_q.size() > 0) ? wr_q[0].addr : 32'h0;
    wr_dqm  = (wr_q.size() > 0) ? wr_q[0].dqm : 8'h00;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] m);
    wreq_t w;
    w.addr = a;
    w.dqm  = m;
    wr_q.push_back(w);
  endtask

  // Arbitration rule evaluated on the pending requests.
  function automatic bit predict_w();
    if (wr_q.size() > 0 && (rd_q.size() == 0 || streak >= STARVE)) return 1'b1;
    return 1'b0;
  endfunction

  // Controller emulation for one complete burst, from grant to the TURN cycle.
  task automatic serve(input string tag, output bit got_w);
    bit exp_w;
    bit found;
    int dly;
    int c4;
    logic [31:0] exp_addr;
    logic [7:0]  exp_dqm;
    logic [15:0] word;
    got_w = 1'b0;
    c4    = 0;
    exp_w = predict_w();
    if (exp_w) begin
      exp_addr = wr_q[0].addr & 32'hFFFF_FFF8;
      exp_dqm  = wr_q[0].dqm;
    end else begin
      exp_addr = rd_q[0] & 32'hFFFF_FFF8;
      exp_dqm  = 8'h00;
    end
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      #1;
      if (sdram_req === 1'b1) found = 1'b1;
      else next_cycle();
    end
    chk($sformatf("%s grant_seen", tag), {31'h0, found}, 32'h1);
    if (!found) return;
    req_cyc = cyc;
    got_w = (sdram_rw === 1'b0);
    chk($sformatf("%s grant_is_write", tag), {31'h0, got_w}, {31'h0, exp_w});
    chk($sformatf("%s sdram_addr", tag), sdram_addr, exp_addr);
    chk($sformatf("%s sdram_dqm", tag), {24'h0, sdram_dqm}, {24'h0, exp_dqm});
    if (exp_w) streak = 0;
    else if (wr_q.size() > 0) streak = (streak < STARVE) ? streak + 1 : streak;
    else streak = 0;
    dly = $urandom_range(0, 2);
    repeat (dly) begin
      next_cycle();
      #1;
      chk($sformatf("%s req_held", tag), {31'h0, sdram_req}, 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      word = 16'($urandom);
      if (exp_w) begin
        sdram_wrstrobe  = 1'b1;
        wr_data         = word;
        sdram_fill      = inject && ($urandom_range(0, 3) == 0);
        data_from_sdram = 16'($urandom);
      end else begin
        sdram_fill      = 1'b1;
        data_from_sdram = word;
        sdram_wrstrobe  = inject && ($urandom_range(0, 3) == 0);
        wr_data         = 16'($urandom);
      end
      if (!exp_w && i == 1) begin
        void'(rd_q.pop_front());
        drive_reqs();
      end
      if (add_wr_mid && i == 2) begin
        push_wr(32'h0000_2004, 8'h00);
        drive_reqs();
        add_wr_mid = 1'b0;
      end
      #1;
      if (exp_w) begin
        chk($sformatf("%s wr_wordreq w%0d", tag, i), {31'h0, wr_wordreq}, 32'h1);
        chk($sformatf("%s wr_wordidx w%0d", tag, i), {30'h0, wr_wordidx}, i);
        chk($sformatf("%s data_to_sdram w%0d", tag, i), {16'h0, data_to_sdram}, {16'h0, word});
        chk($sformatf("%s rd_fill_quiet w%0d", tag, i), {31'h0, rd_fill}, 32'h0);
      end else begin
        chk($sformatf("%s rd_fill w%0d", tag, i), {31'h0, rd_fill}, 32'h1);
        chk($sformatf("%s rd_data w%0d", tag, i), {16'h0, rd_data}, {16'h0, word});
        chk($sformatf("%s wr_wordreq_quiet w%0d", tag, i), {31'h0, wr_wordreq}, 32'h0);
      end
      chk($sformatf("%s sdram_req w%0d", tag, i), {31'h0, sdram_req}, (i == 0) ? 32'h1 : 32'h0);
      chk($sformatf("%s wr_done_early w%0d", tag, i), {31'h0, wr_done}, 32'h0);
      if (i == 3) c4 = cyc;
    end
    next_cycle();
    sdram_fill     = 1'b0;
    sdram_wrstrobe = 1'b0;
    #1;
    chk($sformatf("%s wr_done_turn", tag), {31'h0, wr_done}, {31'h0, exp_w});
    chk($sformatf("%s turn_rd_fill", tag), {31'h0, rd_fill}, 32'h0);
    chk($sformatf("%s turn_req", tag), {31'h0, sdram_req}, 32'h0);
    if (exp_w) begin
      void'(wr_q.pop_front());
      drive_reqs();
    end
    last_c4 = c4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit got;
    bit found;
    int c4r;
    bit exp_seq[10];

    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    //        rd  fill din      req rw  fill data     addr          dqm
    vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 8'hFF};
    vt[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0012_3458, 8'h00};
    vt[2] = '{1'b1, 1'b1, 16'hA000, 1'b1, 1'b1, 1'b1, 16'hA000, 32'h0012_3458, 8'h00};
    vt[3] = '{1'b0, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 16'hA001, 32'h0012_3458, 8'h00};
    vt[4] = '{1'b0, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, 16'hA002, 32'h0012_3458, 8'h00};
    vt[5] = '{1'b0, 1'b1, 16'hA003, 1'b0, 1'b1, 1'b1, 16'hA003, 32'h0012_3458, 8'h00};
    vt[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0012_3458, 8'h00};
    vt[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0012_3458, 8'hFF};

    reset = 1'b1;
    rd_req = 1'b0; rd_addr = 32'h0;
    wr_req = 1'b0; wr_addr = 32'h0; wr_dqm = 8'h00; wr_data = 16'h0;
    sdram_fill = 1'b0; sdram_wrstrobe = 1'b0; data_from_sdram = 16'h0;
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    chk("reset sdram_req", {31'h0, sdram_req}, 32'h0);
    chk("reset sdram_rw", {31'h0, sdram_rw}, 32'h1);
    chk("reset sdram_addr", sdram_addr, 32'h0);
    chk("reset sdram_dqm", {24'h0, sdram_dqm}, 32'hFF);
    chk("reset wr_done", {31'h0, wr_done}, 32'h0);

    // Read-only burst from the vector table.
    rd_addr = 32'h0012_345E;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      rd_req          = vt[i].rd;
      sdram_fill      = vt[i].fill;
      data_from_sdram = vt[i].din;
      #1;
      chk($sformatf("vec%0d sdram_req", i), {31'h0, sdram_req}, {31'h0, vt[i].e_req});
      chk($sformatf("vec%0d sdram_rw", i), {31'h0, sdram_rw}, {31'h0, vt[i].e_rw});
      chk($sformatf("vec%0d rd_fill", i), {31'h0, rd_fill}, {31'h0, vt[i].e_fill});
      if (vt[i].e_fill) chk($sformatf("vec%0d rd_data", i), {16'h0, rd_data}, {16'h0, vt[i].e_data});
      chk($sformatf("vec%0d sdram_addr", i), sdram_addr, vt[i].e_addr);
      chk($sformatf("vec%0d sdram_dqm", i), {24'h0, sdram_dqm}, {24'h0, vt[i].e_dqm});
      chk($sformatf("vec%0d wr_wordreq", i), {31'h0, wr_wordreq}, 32'h0);
    end
    rd_addr = 32'h0;
    sdram_fill = 1'b0;

    // Write-only burst.
    next_cycle();
    push_wr(32'h0000_0100, 8'b0011_0000);
    drive_reqs();
    serve("wronly", got);
    next_cycle();
    #1;
    chk("wronly wr_done_single", {31'h0, wr_done}, 32'h0);

    // Stray strobes while idle, then a read must still take all 4 fills.
    sdram_fill = 1'b1;
    data_from_sdram = 16'hBEEF;
    #1;
    chk("stray rd_fill", {31'h0, rd_fill}, 32'h0);
    next_cycle();
    sdram_fill = 1'b0;
    sdram_wrstrobe = 1'b1;
    #1;
    chk("stray wr_wordreq", {31'h0, wr_wordreq}, 32'h0);
    chk("stray sdram_req", {31'h0, sdram_req}, 32'h0);
    next_cycle();
    sdram_wrstrobe = 1'b0;
    rd_q.push_back(32'h0000_0A10);
    drive_reqs();
    serve("stray_rd", got);
    chk("stray_rd kind", {31'h0, got}, 32'h0);

    // Both requesters held: fixed grant order.
    for (int i = 0; i < 8; i++) rd_q.push_back(32'h0001_0000 + 32'(i * 8));
    push_wr(32'h0002_0000, 8'h0F);
    push_wr(32'h0002_0008, 8'hF0);
    next_cycle();
    drive_reqs();
    for (int g = 0; g < 10; g++) begin
      serve($sformatf("simul%0d", g), got);
      chk($sformatf("simul order%0d", g), {31'h0, got}, {31'h0, exp_seq[g]});
    end

    // Write request raised during a read burst.
    next_cycle();
    rd_q.push_back(32'h0000_4444);
    drive_reqs();
    add_wr_mid = 1'b1;
    serve("turn_rd", got);
    chk("turn_rd kind", {31'h0, got}, 32'h0);
    c4r = last_c4;
    serve("turn_wr", got);
    chk("turn_wr kind", {31'h0, got}, 32'h1);
    chk("turnaround gap", req_cyc - c4r, 32'd3);

    // Reset after the 2nd write strobe.
    next_cycle();
    push_wr(32'h0000_0300, 8'h0F);
    drive_reqs();
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      #1;
      if (sdram_req === 1'b1) found = 1'b1;
      else next_cycle();
    end
    chk("rstmid grant_seen", {31'h0, found}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      sdram_wrstrobe = 1'b1;
      wr_data = 16'h5500 + 16'(i);
      #1;
      chk($sformatf("rstmid wordidx%0d", i), {30'h0, wr_wordidx}, i);
    end
    next_cycle();
    reset = 1'b1;
    wr_q.delete();
    drive_reqs();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rstmid sdram_req", {31'h0, sdram_req}, 32'h0);
    chk("rstmid sdram_dqm", {24'h0, sdram_dqm}, 32'hFF);
    chk("rstmid sdram_rw", {31'h0, sdram_rw}, 32'h1);
    chk("rstmid wr_done", {31'h0, wr_done}, 32'h0);
    chk("rstmid wr_wordreq a", {31'h0, wr_wordreq}, 32'h0);
    next_cycle();
    #1;
    chk("rstmid wr_wordreq b", {31'h0, wr_wordreq}, 32'h0);
    chk("rstmid wr_done b", {31'h0, wr_done}, 32'h0);
    next_cycle();
    sdram_wrstrobe = 1'b0;
    streak = 0;
    rd_q.push_back(32'h0000_0777);
    drive_reqs();
    serve("post_rst", got);
    chk("post_rst kind", {31'h0, got}, 32'h0);

    // Randomised traffic against the queue model.
    for (int it = 0; it < 60; it++) begin
      next_cycle();
      sdram_fill = 1'b0;
      sdram_wrstrobe = 1'b0;
      if (rd_q.size() < 3 && $urandom_range(0, 2) != 0) rd_q.push_back($urandom);
      if (wr_q.size() < 3 && $urandom_range(0, 2) == 0) push_wr($urandom, 8'($urandom));
      drive_reqs();
      inject = 1'($urandom_range(0, 1));
      if (rd_q.size() == 0 && wr_q.size() == 0) begin
        sdram_fill = 1'($urandom_range(0, 1));
        sdram_wrstrobe = !sdram_fill;
        #1;
        chk($sformatf("rnd%0d idle rd_fill", it), {31'h0, rd_fill}, 32'h0);
        chk($sformatf("rnd%0d idle wr_wordreq", it), {31'h0, wr_wordreq}, 32'h0);
      end else begin
        serve($sformatf("rnd%0d", it), got);
      end
    end
    inject = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller burst port between two requesters: the two-way cache's line-fill reads (port R) and the write-combining buffer's 4-word write flushes (port W).
- Grants a whole 4-word burst at a time and routes the controller's per-word strobes and data to the granted requester.
- Read priority, with a starvation limit that guarantees write progress.

Parameters:
- WR_STARVE_MAX, 4: consecutive read grants allowed while a write is pending before the write is forced to win.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  cache fill request; level, held until the first rd_fill
- rd_addr  in  ADDR_W  fill address; bits 2:0 ignored
- rd_fill  out  1  word strobe to the cache, one per burst word
- rd_data  out  16  fill word, valid with rd_fill
- wr_req  in  1  write buffer flush request; level, held until wr_done
- wr_addr  in  ADDR_W  flush address; bits 2:0 ignored
- wr_dqm  in  8  byte masks for the 4 words (1 = masked); 2 bits per word, word0 = bits 1:0, upper byte = the higher bit of each pair
- wr_wordreq  out  1  the buffer must present the word wr_wordidx on wr_data this cycle
- wr_wordidx  out  2  index of the word being written
- wr_data  in  16  write word
- wr_done  out  1  one-cycle pulse after the 4th word is written
- sdram_req  out  1  request to the controller
- sdram_rw  out  1  1 = read, 0 = write
- sdram_addr  out  ADDR_W  burst address, bits 2:0 forced to 0
- sdram_dqm  out  8  byte masks for the current burst
- data_to_sdram  out  16  write word
- sdram_fill  in  1  read data word valid (4 consecutive cycles)
- data_from_sdram  in  16  read data
- sdram_wrstrobe  in  1  controller consumes a write word this cycle (4 consecutive cycles)

Behaviour:
- Reset values: state=IDLE, sdram_req=0, sdram_rw=1, sdram_addr=0, sdram_dqm=8'hFF, wr_done=0, word counter=0, starvation counter=0.
- Reset takes effect in any state, mid-burst included; any strobes arriving afterwards are ignored.
- State IDLE, with only rd_req: grant R.
  - Register sdram_addr={rd_addr[ADDR_W-1:3],3'b000}, sdram_rw=1, sdram_req=1, sdram_dqm=0.
  - Go to RD_BURST.
- State IDLE, with only wr_req: grant W.
  - Register the address the same way, plus sdram_rw=0, sdram_dqm=wr_dqm, sdram_req=1.
  - Go to WR_BURST.
- State IDLE, with both requests:
  - Grant W if the starvation counter == WR_STARVE_MAX; otherwise grant R.
  - An R grant with wr_req pending increments the counter (saturating).
  - Any W grant clears the counter; an R grant with no wr_req also clears it.
- sdram_req is set in the grant cycle. It stays high until the first sdram_fill or sdram_wrstrobe is sampled, then clears in the next cycle.
- RD_BURST:
  - rd_fill = sdram_fill and rd_data = data_from_sdram, both combinational with zero latency.
  - The 2-bit counter increments per strobe. After the 4th strobe go to TURN.
- WR_BURST:
  - wr_wordreq = sdram_wrstrobe (combinational); wr_wordidx = counter; data_to_sdram = wr_data (combinational).
  - The counter increments per strobe. On the 4th strobe, register wr_done=1 for one cycle and go to TURN.
- TURN: one idle cycle; clears the counter and sets sdram_dqm=8'hFF; then IDLE. No grant is ever made in TURN, so back-to-back bursts are separated by at least 1 cycle.
- Outside the matching state:
  - rd_fill=0 and wr_wordreq=0.
  - A stray strobe is ignored: no counter change, no state change.
- Request inputs are sampled only in IDLE; request or address changes during a burst have no effect.
- Counter wraps 3→0 only on leaving the burst state.
- sdram_fill and sdram_wrstrobe both high in the same cycle is a controller error. Only the strobe matching the current state is honoured.

Test Plan:
- Read only: rd_req with rd_addr=32'h0012_345E.
  - Required: sdram_addr=32'h0012_3458, sdram_rw=1 one cycle after the request.
  - Required: four sdram_fill words 0xA000..0xA003 appear on rd_data in the same cycles.
  - Required: sdram_req drops the cycle after the first fill.
- Write only: wr_addr=32'h100, wr_dqm=8'b00110000.
  - Required: sdram_dqm=8'h30, sdram_rw=0, wr_wordidx=0,1,2,3 on successive strobes.
  - Required: data_to_sdram mirrors wr_data; wr_done pulses exactly once, one cycle after the 4th strobe.
- Simultaneous: rd_req and wr_req held continuously.
  - Required grant order: R,R,R,R,W,R,R,R,R,W (with WR_STARVE_MAX=4).
- Turnaround: wr_req asserted during a read burst.
  - Required: W granted no earlier than 2 cycles after the 4th fill; the TURN cycle is observed.
- Reset mid-burst: reset=1 after the 2nd write strobe.
  - Required: next cycle state=IDLE, sdram_req=0, sdram_dqm=8'hFF, no wr_done.
  - Required: the 2 following strobes produce no wr_wordreq.
- Stray strobe: sdram_fill pulsed while IDLE.
  - Required: rd_fill stays 0, counter stays 0, no state change.
